// File: rtl/dcache_wbuf_if.sv
// dcache_wbuf_if: bus bundle between the data cache, the write-back line
// buffer and the data memory.
//   slave  modport: the write-back buffer's view (cache requests in, memory
//                   requests out).
//   master modport: the environment's view (drives cache requests and the
//                   memory responses).
// Signals:
//   cache_enable_i / cache_write_i / cache_addr_i / cache_data_i : cache request
//   cache_ack_o / cache_data_o                                   : cache response
//   mem_enable_o / mem_write_o / mem_addr_o / mem_data_o         : memory request
//   mem_ack_i / mem_data_i                                       : memory response
interface dcache_wbuf_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              cache_enable_i;
  logic              cache_write_i;
  logic [ADDR_W-1:0] cache_addr_i;
  logic [LINE_W-1:0] cache_data_i;
  logic              cache_ack_o;
  logic [LINE_W-1:0] cache_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_i;

  modport slave (
    input  cache_enable_i, cache_write_i, cache_addr_i, cache_data_i,
    input  mem_ack_i, mem_data_i,
    output cache_ack_o, cache_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cache_enable_i, cache_write_i, cache_addr_i, cache_data_i,
    output mem_ack_i, mem_data_i,
    input  cache_ack_o, cache_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_wbuf.sv
// dcache_wbuf: write-back line buffer between the dcache memory port and the
// data memory. Dirty-line write-backs are absorbed into a DEPTH-entry FIFO and
// acknowledged in one cycle; buffered lines drain to memory in the background.
// Writes to a line already buffered (and not currently draining) coalesce in
// place. Refill reads go to memory through a small IDLE/DRAIN/READ/RESP FSM.
// Optional feature macro: WBUF_FWD_EN
//   defined   : reads that match a buffered line are answered from the buffer,
//               and read misses go to memory ahead of pending drains.
//   undefined : reads wait until the buffer is empty and the FSM is idle.
// Ports:
//   clk_i : clock, all state updates on posedge
//   rst_i : asynchronous active-high reset
//   bus   : dcache_wbuf_if.slave (cache request/response, memory request/response)
module dcache_wbuf #(
  parameter int DEPTH  = 2,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  dcache_wbuf_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LA_W  = ADDR_W - 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [DEPTH-1:0]  valid_r;
  logic [LA_W-1:0]   laddr_r [DEPTH];
  logic [LINE_W-1:0] data_r  [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  logic              cache_ack_r;
  logic [LINE_W-1:0] cache_data_r;
  logic              mem_enable_r;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [LINE_W-1:0] mem_data_r;

  logic [LA_W-1:0]   req_line_s;
  logic              new_req_s;
  logic              wr_req_s;
  logic              rd_req_s;
  logic              pop_s;
  logic              start_read_s;
  logic              start_drain_s;
  logic              drain_lock_s;
  logic              rd_fwd_s;
  logic              wr_hit_s;
  logic              wr_sel_s;
  logic [PTR_W-1:0]  wr_idx_s;
  logic [PTR_W-1:0]  wr_scan_s;
  logic              coalesce_s;
  logic              enq_s;
  logic              unused_s;

  assign req_line_s = bus.cache_addr_i[ADDR_W-1:5];
  assign unused_s   = ^bus.cache_addr_i[4:0];

  // Holding enable through the ack cycle must not start a second transaction.
  assign new_req_s = bus.cache_enable_i && !cache_ack_r;
  assign wr_req_s  = new_req_s && bus.cache_write_i;
  assign rd_req_s  = new_req_s && !bus.cache_write_i && (state_r != READ) && (state_r != RESP);
  assign pop_s     = (state_r == DRAIN) && bus.mem_ack_i;

`ifdef WBUF_FWD_EN
  logic              rd_hit_s;
  logic              rd_match_s;
  logic [PTR_W-1:0]  rd_idx_s;
  logic [PTR_W-1:0]  rd_scan_s;

  // Youngest buffered entry matching the read line (scan oldest to youngest).
  always_comb begin
    rd_hit_s   = 1'b0;
    rd_idx_s   = head_r;
    rd_scan_s  = head_r;
    rd_match_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_scan_s  = head_r + PTR_W'(k);
      rd_match_s = valid_r[rd_scan_s] && (laddr_r[rd_scan_s] == req_line_s);
      rd_hit_s   = rd_hit_s || rd_match_s;
      rd_idx_s   = rd_match_s ? rd_scan_s : rd_idx_s;
    end
  end

  assign rd_fwd_s     = rd_req_s && rd_hit_s;
  // A miss has no buffered copy, so it may overtake queued drains.
  assign start_read_s = (state_r == IDLE) && rd_req_s && !rd_hit_s;
`else
  assign rd_fwd_s     = 1'b0;
  assign start_read_s = (state_r == IDLE) && rd_req_s && (count_r == {CNT_W{1'b0}});
`endif

  assign start_drain_s = (state_r == IDLE) && !start_read_s && (count_r != {CNT_W{1'b0}});
  // The head is locked from the edge its data is captured into mem_data_r.
  assign drain_lock_s  = (state_r == DRAIN) || start_drain_s;

  // Youngest buffered entry the write may coalesce into (never the draining head).
  always_comb begin
    wr_hit_s  = 1'b0;
    wr_idx_s  = head_r;
    wr_scan_s = head_r;
    wr_sel_s  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      wr_scan_s = head_r + PTR_W'(k);
      wr_sel_s  = valid_r[wr_scan_s] && (laddr_r[wr_scan_s] == req_line_s) &&
                  !(drain_lock_s && (wr_scan_s == head_r));
      wr_hit_s  = wr_hit_s || wr_sel_s;
      wr_idx_s  = wr_sel_s ? wr_scan_s : wr_idx_s;
    end
  end

  assign coalesce_s = wr_req_s && wr_hit_s;
  // A full buffer still accepts on the edge the head pops (tail == head then).
  assign enq_s      = wr_req_s && !wr_hit_s && ((count_r != CNT_W'(DEPTH)) || pop_s);

  // Line storage, FIFO pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= {DEPTH{1'b0}};
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        laddr_r[k] <= {LA_W{1'b0}};
        data_r[k]  <= {LINE_W{1'b0}};
      end
    end else begin
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + 1'b1;
      end
      if (coalesce_s) begin
        data_r[wr_idx_s] <= bus.cache_data_i;
      end
      // Placed after the pop so a same-edge refill of that slot stays valid.
      if (enq_s) begin
        valid_r[tail_r] <= 1'b1;
        laddr_r[tail_r] <= req_line_s;
        data_r[tail_r]  <= bus.cache_data_i;
        tail_r          <= tail_r + 1'b1;
      end
      case ({enq_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Memory FSM with registered cache and memory outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      cache_ack_r  <= 1'b0;
      cache_data_r <= {LINE_W{1'b0}};
      mem_enable_r <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_data_r   <= {LINE_W{1'b0}};
    end else begin
      cache_ack_r <= enq_s || coalesce_s || rd_fwd_s;
`ifdef WBUF_FWD_EN
      if (rd_fwd_s) begin
        cache_data_r <= data_r[rd_idx_s];
      end
`endif
      case (state_r)
        IDLE: begin
          if (start_read_s) begin
            state_r      <= READ;
            mem_enable_r <= 1'b1;
            mem_write_r  <= 1'b0;
            mem_addr_r   <= {req_line_s, 5'b00000};
          end else if (start_drain_s) begin
            state_r      <= DRAIN;
            mem_enable_r <= 1'b1;
            mem_write_r  <= 1'b1;
            mem_addr_r   <= {laddr_r[head_r], 5'b00000};
            mem_data_r   <= data_r[head_r];
          end else begin
            state_r <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.mem_ack_i) begin
            state_r      <= IDLE;
            mem_enable_r <= 1'b0;
          end else begin
            state_r <= DRAIN;
          end
        end
        READ: begin
          if (bus.mem_ack_i) begin
            state_r      <= RESP;
            mem_enable_r <= 1'b0;
            cache_data_r <= bus.mem_data_i;
            cache_ack_r  <= 1'b1;
          end else begin
            state_r <= READ;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.cache_ack_o  = cache_ack_r;
  assign bus.cache_data_o = cache_data_r;
  assign bus.mem_enable_o = mem_enable_r;
  assign bus.mem_write_o  = mem_write_r;
  assign bus.mem_addr_o   = mem_addr_r;
  assign bus.mem_data_o   = mem_data_r;
endmodule
